quad_bcd_counter: RTL and testbench

Synchronous, parametrised successor to the mod-100 impulse counter. Samples a quadrature encoder (SIA/SIB) on the system clock, synchronises and debounces both phases, decodes steps in x1 or x4 mode, and maintains an N-digit BCD up/down count with wrap. It adds load, enable, a step pulse, wrap and error flags, and feeds display/BCD-to-7-segment logic directly.

---
 rtl/quad_bcd_pkg.sv | 50 +++++
 rtl/quad_input_filter.sv | 65 ++++++
 rtl/quad_bcd_counter.sv | 175 +++++++++++++++++
 tb/tb_quad_bcd_counter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : quad_bcd_pkg
//  Purpose  : Shared constants, quadrature phase encodings and the x4 step
//             decode function for the quadrature BCD counter.
//  Revision : 1.0  initial release
// ============================================================================
package quad_bcd_pkg;

   localparam int MODE_X1 = 0;
   localparam int MODE_X4 = 1;

   localparam int              BCD_W   = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   // Phase states written as {A,B}; forward rotation is 00 -> 10 -> 11 -> 01.
   typedef enum logic [1:0] {
      PH_00 = 2'b00,
      PH_01 = 2'b01,
      PH_10 = 2'b10,
      PH_11 = 2'b11
   } phase_e;

   typedef enum logic [1:0] {
      DEC_NONE = 2'd0,
      DEC_UP   = 2'd1,
      DEC_DOWN = 2'd2,
      DEC_ERR  = 2'd3
   } dec_e;

   // Next phase state when turning in the "up" direction.
   function automatic logic [1:0] phase_succ(input logic [1:0] ph);
      case (ph)
         PH_00:   return PH_10;
         PH_10:   return PH_11;
         PH_11:   return PH_01;
         default: return PH_00;
      endcase
   endfunction

   // Classify a previous/current phase pair; a two-bit jump is illegal.
   function automatic dec_e decode_x4(input logic [1:0] prev, input logic [1:0] curr);
      if (prev == curr)                   return DEC_NONE;
      else if (curr == phase_succ(prev))  return DEC_UP;
      else if (prev == phase_succ(curr))  return DEC_DOWN;
      else                                return DEC_ERR;
   endfunction

endpackage
`default_nettype wire

// File: rtl/quad_input_filter.sv
`default_nettype none
// ============================================================================
//  Module   : quad_input_filter
//  Purpose  : Multi-flop synchroniser followed by a consecutive-cycle
//             debounce filter for one asynchronous encoder phase.
//  Revision : 1.0  initial release
// ============================================================================
module quad_input_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic async_i,
   output logic filt_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_w;

   // Shift the raw pin through the synchroniser chain.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
   end

   assign sync_w = sync_q[SYNC_STAGES-1];

   generate
      if (DEB_CYCLES == 0) begin : g_bypass
         assign filt_o = sync_w;
      end else begin : g_deb
         localparam int            CW       = $clog2(DEB_CYCLES + 1);
         localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

         logic [CW-1:0] cnt_q, cnt_d;
         logic          filt_q, filt_d;

         // Count consecutive mismatching cycles; accept the new level on the last one.
         always_comb begin
            cnt_d  = '0;
            filt_d = filt_q;
            if (sync_w != filt_q) begin
               if (cnt_q == CNT_LAST) filt_d = sync_w;
               else                   cnt_d  = cnt_q + CW'(1);
            end
         end

         // Debounce state register.
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               cnt_q  <= '0;
               filt_q <= 1'b0;
            end else begin
               cnt_q  <= cnt_d;
               filt_q <= filt_d;
            end
         end

         assign filt_o = filt_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/quad_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : quad_bcd_counter
//  Purpose  : Quadrature encoder decoder (x1 / x4) driving an N-digit BCD
//             up/down counter with wrap, load, clear, enable and error flag.
//  Revision : 1.0  initial release
// ============================================================================
module quad_bcd_counter
   import quad_bcd_pkg::*;
#(
   parameter int DIGITS      = 2,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 16,
   parameter int MODE        = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    sia_i,
   input  logic                    sib_i,
   input  logic                    sw_i,
   input  logic                    en_i,
   input  logic                    load_i,
   input  logic [BCD_W*DIGITS-1:0] load_val_i,
   output logic [BCD_W*DIGITS-1:0] count_o,
   output logic                    dir_o,
   output logic                    step_o,
   output logic                    wrap_o,
   output logic                    err_o
);

   localparam int CW = BCD_W * DIGITS;
   // Priming window spans the full input pipeline so a pin level present at
   // reset release is absorbed as the initial phase, never as a step.
   localparam int            PRIME_CYC  = SYNC_STAGES + DEB_CYCLES + 1;
   localparam int            PW         = $clog2(PRIME_CYC + 1);
   localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_CYC - 1);

   logic             filt_a_w, filt_b_w;
   logic [1:0]       ab_w, prev_ab_q;
   logic             primed_q, primed_d;
   logic [PW-1:0]    prime_cnt_q, prime_cnt_d;
   logic [SYNC_STAGES-1:0] sw_q;
   logic             sw_w;
   dec_e             dec_w;
   logic [CW-1:0]    nxt_w, load_clamp_w;
   logic             roll_w;
   logic [CW-1:0]    count_q, count_d;
   logic             dir_q, dir_d, step_q, step_d, wrap_q, wrap_d, err_q, err_d;

   quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_filt_a (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .async_i (sia_i),
      .filt_o  (filt_a_w)
   );

   quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_filt_b (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .async_i (sib_i),
      .filt_o  (filt_b_w)
   );

   assign ab_w = {filt_a_w, filt_b_w};
   assign sw_w = sw_q[SYNC_STAGES-1];

   // Clear button synchroniser (no debounce: a bounce just clears again).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sw_q <= '0;
      else          sw_q <= {sw_q[SYNC_STAGES-2:0], sw_i};
   end

   // Priming: first phase update or end of settle window arms the decoder.
   always_comb begin
      primed_d    = primed_q;
      prime_cnt_d = prime_cnt_q;
      if (!primed_q) begin
         prime_cnt_d = prime_cnt_q + PW'(1);
         if ((ab_w != prev_ab_q) || (prime_cnt_q == PRIME_LAST)) primed_d = 1'b1;
      end
   end

   // Step decode from previous and current filtered phases.
   always_comb begin
      dec_w = DEC_NONE;
      if (primed_q) begin
         if (MODE == MODE_X4)                dec_w = decode_x4(prev_ab_q, ab_w);
         else if (!prev_ab_q[1] && ab_w[1])  dec_w = ab_w[0] ? DEC_DOWN : DEC_UP;
      end
   end

   // Single-cycle BCD increment/decrement with ripple carry or borrow.
   always_comb begin
      logic             carry;
      logic [BCD_W-1:0] dig;
      carry = 1'b1;
      nxt_w = count_q;
      dig   = '0;
      for (int i = 0; i < DIGITS; i++) begin
         dig = count_q[i*BCD_W +: BCD_W];
         if (carry) begin
            if (dec_w != DEC_DOWN) begin
               if (dig == BCD_MAX) dig = '0;
               else begin dig = dig + 4'd1; carry = 1'b0; end
            end else begin
               if (dig == '0) dig = BCD_MAX;
               else begin dig = dig - 4'd1; carry = 1'b0; end
            end
         end
         nxt_w[i*BCD_W +: BCD_W] = dig;
      end
      roll_w = carry;
   end

   // Clamp each preset digit into the decimal range.
   always_comb begin
      load_clamp_w = '0;
      for (int i = 0; i < DIGITS; i++) begin
         load_clamp_w[i*BCD_W +: BCD_W] = (load_val_i[i*BCD_W +: BCD_W] > BCD_MAX) ?
                                          BCD_MAX : load_val_i[i*BCD_W +: BCD_W];
      end
   end

   // Counter update: clear beats load beats an enabled step.
   always_comb begin
      count_d = count_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      err_d   = err_q;
      if (dec_w == DEC_ERR) err_d = 1'b1;
      if (sw_w) begin
         count_d = '0;
         err_d   = 1'b0;
      end else if (load_i) begin
         count_d = load_clamp_w;
      end else if (en_i && ((dec_w == DEC_UP) || (dec_w == DEC_DOWN))) begin
         count_d = nxt_w;
         step_d  = 1'b1;
         wrap_d  = roll_w;
         dir_d   = (dec_w == DEC_DOWN);
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         prev_ab_q   <= 2'b00;
         primed_q    <= 1'b0;
         prime_cnt_q <= '0;
         count_q     <= '0;
         dir_q       <= 1'b0;
         step_q      <= 1'b0;
         wrap_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         prev_ab_q   <= ab_w;
         primed_q    <= primed_d;
         prime_cnt_q <= prime_cnt_d;
         count_q     <= count_d;
         dir_q       <= dir_d;
         step_q      <= step_d;
         wrap_q      <= wrap_d;
         err_q       <= err_d;
      end
   end

   assign count_o = count_q;
   assign dir_o   = dir_q;
   assign step_o  = step_q;
   assign wrap_o  = wrap_q;
   assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quad_bcd_counter
//  Purpose  : Scoreboard bench for quad_bcd_counter: x1 two-digit, x4
//             two-digit and x1 three-digit instances.
//  Revision : 1.0  initial release
// ============================================================================
module tb_quad_bcd_counter;

   typedef struct packed {
      logic [11:0] count;
      logic        dir;
      logic        wrap;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sia[3], sib[3], sw[3], en[3], load[3];
   logic [11:0] lval[3];
   logic [7:0]  cnt0, cnt1;
   logic [11:0] cnt2;
   logic [11:0] cnt_w[3];
   logic        step_w[3], dir_w[3], wrap_w[3], err_w[3];

   exp_t q0[$], q1[$], q2[$];
   int   mdl[3];
   int   nsteps[3];
   int   checks = 0;
   int   errors = 0;
   int   lat;
   int   nsave;

   always #5 clk = ~clk;

   assign cnt_w[0] = {4'h0, cnt0};
   assign cnt_w[1] = {4'h0, cnt1};
   assign cnt_w[2] = cnt2;

   quad_bcd_counter #(.DIGITS(2), .SYNC_STAGES(2), .DEB_CYCLES(4), .MODE(0)) u_x1 (
      .clk_i(clk), .rst_n_i(rst_n), .sia_i(sia[0]), .sib_i(sib[0]), .sw_i(sw[0]),
      .en_i(en[0]), .load_i(load[0]), .load_val_i(lval[0][7:0]), .count_o(cnt0),
      .dir_o(dir_w[0]), .step_o(step_w[0]), .wrap_o(wrap_w[0]), .err_o(err_w[0]));

   quad_bcd_counter #(.DIGITS(2), .SYNC_STAGES(2), .DEB_CYCLES(4), .MODE(1)) u_x4 (
      .clk_i(clk), .rst_n_i(rst_n), .sia_i(sia[1]), .sib_i(sib[1]), .sw_i(sw[1]),
      .en_i(en[1]), .load_i(load[1]), .load_val_i(lval[1][7:0]), .count_o(cnt1),
      .dir_o(dir_w[1]), .step_o(step_w[1]), .wrap_o(wrap_w[1]), .err_o(err_w[1]));

   quad_bcd_counter #(.DIGITS(3), .SYNC_STAGES(2), .DEB_CYCLES(4), .MODE(0)) u_d3 (
      .clk_i(clk), .rst_n_i(rst_n), .sia_i(sia[2]), .sib_i(sib[2]), .sw_i(sw[2]),
      .en_i(en[2]), .load_i(load[2]), .load_val_i(lval[2]), .count_o(cnt2),
      .dir_o(dir_w[2]), .step_o(step_w[2]), .wrap_o(wrap_w[2]), .err_o(err_w[2]));

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // Expected response of one accepted step, from a decimal model.
   task automatic push_step(input int i, input bit down);
      int   m;
      exp_t e;
      m      = (i == 2) ? 1000 : 100;
      e.wrap = down ? (mdl[i] == 0) : (mdl[i] == m - 1);
      mdl[i] = down ? (mdl[i] + m - 1) % m : (mdl[i] + 1) % m;
      e.count = to_bcd(mdl[i]);
      e.dir   = down;
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic sb_pop(input int i, output exp_t e, output bit ok);
      ok = 1'b1;
      e  = '0;
      case (i)
         0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
         1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
         default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
      endcase
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ab(input int i, input logic a, input logic b, input int hold);
      sia[i] = a;
      sib[i] = b;
      wait_cyc(hold);
   endtask

   task automatic x1_step(input int i, input bit down);
      if (down) set_ab(i, 1'b0, 1'b1, 10);
      push_step(i, down);
      set_ab(i, 1'b1, down, 10);
      set_ab(i, 1'b0, down, 10);
      if (down) set_ab(i, 1'b0, 1'b0, 10);
   endtask

   task automatic do_load(input int i, input logic [11:0] v);
      lval[i] = v;
      load[i] = 1'b1;
      wait_cyc(1);
      load[i] = 1'b0;
   endtask

   // Monitor: every STEP pulse is matched against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      bit   ok;
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (step_w[i]) begin
               nsteps[i]++;
               sb_pop(i, e, ok);
               if (!ok) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_step[%0d]: count=%0h with nothing expected", i, cnt_w[i]);
               end else begin
                  chk("mon_count", i, cnt_w[i], e.count);
                  chk("mon_dir",   i, dir_w[i],  e.dir);
                  chk("mon_wrap",  i, wrap_w[i], e.wrap);
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sia[i] = 0; sib[i] = 0; sw[i] = 0; en[i] = 1; load[i] = 0; lval[i] = '0;
         mdl[i] = 0; nsteps[i] = 0;
      end
      wait_cyc(3);
      for (int i = 0; i < 3; i++) begin
         chk("rst_count", i, cnt_w[i], 0);
         chk("rst_flags", i, {step_w[i], dir_w[i], wrap_w[i], err_w[i]}, 0);
      end
      rst_n = 1'b1;
      wait_cyc(12);

      // ---- x1, two digits: latency of first step, then 12 steps total
      push_step(0, 0);
      sia[0] = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (step_w[0] && lat == 0) lat = k;
      end
      chk("latency", 0, lat, 7);
      set_ab(0, 1'b0, 1'b0, 10);
      for (int k = 0; k < 11; k++) x1_step(0, 0);
      chk("count_12", 0, cnt_w[0], 12'h012);
      chk("nsteps_12", 0, nsteps[0], 12);

      // ---- wrap up from 99, then down from 00
      do_load(0, 12'h099);
      chk("load_99", 0, cnt_w[0], 12'h099);
      mdl[0] = 99;
      push_step(0, 0);
      sia[0] = 1'b1;
      wait_cyc(7);
      chk("wrap_hi", 0, wrap_w[0], 1);
      wait_cyc(1);
      chk("wrap_pulse", 0, wrap_w[0], 0);
      wait_cyc(2);
      set_ab(0, 1'b0, 1'b0, 10);
      chk("wrap_count", 0, cnt_w[0], 12'h000);
      x1_step(0, 1);
      chk("down_count", 0, cnt_w[0], 12'h099);
      chk("down_dir", 0, dir_w[0], 1);

      // ---- glitch rejection then a just-long-enough pulse
      sia[0] = 1'b1;
      wait_cyc(3);
      sia[0] = 1'b0;
      wait_cyc(12);
      chk("glitch", 0, cnt_w[0], 12'h099);
      push_step(0, 0);
      sia[0] = 1'b1;
      wait_cyc(5);
      sia[0] = 1'b0;
      wait_cyc(12);
      chk("pulse5", 0, cnt_w[0], 12'h000);

      // ---- load coincident with a decoded step; preset digit clamped
      nsave = nsteps[0];
      sia[0] = 1'b1;
      wait_cyc(6);
      do_load(0, 12'h05C);
      chk("load_clamp", 0, cnt_w[0], 12'h059);
      chk("load_nostep", 0, step_w[0], 0);
      mdl[0] = 59;
      wait_cyc(10);
      set_ab(0, 1'b0, 1'b0, 10);
      chk("load_nsteps", 0, nsteps[0], nsave);

      // ---- enable low: steps discarded
      en[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_ab(0, 1'b1, 1'b0, 10);
         set_ab(0, 1'b0, 1'b0, 10);
      end
      en[0] = 1'b1;
      chk("en_low_count", 0, cnt_w[0], 12'h059);
      chk("en_low_nsteps", 0, nsteps[0], nsave);

      // ---- x4: full forward cycle, illegal jump, clear, down wrap
      push_step(1, 0); set_ab(1, 1'b1, 1'b0, 10);
      push_step(1, 0); set_ab(1, 1'b1, 1'b1, 10);
      push_step(1, 0); set_ab(1, 1'b0, 1'b1, 10);
      push_step(1, 0); set_ab(1, 1'b0, 1'b0, 10);
      chk("x4_cycle", 1, cnt_w[1], 12'h004);
      chk("x4_noerr", 1, err_w[1], 0);
      set_ab(1, 1'b1, 1'b1, 10);
      chk("x4_err", 1, err_w[1], 1);
      chk("x4_err_count", 1, cnt_w[1], 12'h004);
      sw[1] = 1'b1;
      wait_cyc(2);
      sw[1] = 1'b0;
      wait_cyc(5);
      chk("sw_count", 1, cnt_w[1], 12'h000);
      chk("sw_err", 1, err_w[1], 0);
      mdl[1] = 0;
      push_step(1, 1); set_ab(1, 1'b1, 1'b0, 10);
      chk("x4_down_count", 1, cnt_w[1], 12'h099);
      chk("x4_down_dir", 1, dir_w[1], 1);
      set_ab(1, 1'b0, 1'b1, 10);
      chk("x4_err2", 1, err_w[1], 1);

      // ---- three digits: wrap at 999 both ways
      do_load(2, 12'h998);
      chk("load_998", 2, cnt_w[2], 12'h998);
      mdl[2] = 998;
      x1_step(2, 0);
      chk("d3_999", 2, cnt_w[2], 12'h999);
      x1_step(2, 0);
      chk("d3_wrap", 2, cnt_w[2], 12'h000);
      x1_step(2, 1);
      chk("d3_down", 2, cnt_w[2], 12'h999);

      // ---- asynchronous reset in the middle of a debounce
      sia[2] = 1'b1;
      wait_cyc(4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_count", 2, cnt_w[2], 12'h000);
      chk("arst_flags", 2, {step_w[2], dir_w[2], wrap_w[2]}, 0);
      chk("arst_err", 1, err_w[1], 0);
      chk("arst_count", 1, cnt_w[1], 12'h000);
      wait_cyc(2);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mdl[i] = 0;
         nsteps[i] = 0;
      end
      wait_cyc(20);
      chk("post_rst_count", 2, cnt_w[2], 12'h000);
      chk("post_rst_nsteps", 2, nsteps[2], 0);
      chk("post_rst_nsteps", 1, nsteps[1], 0);
      set_ab(2, 1'b0, 1'b0, 10);
      push_step(2, 0);
      set_ab(2, 1'b1, 1'b0, 10);
      set_ab(2, 1'b0, 1'b0, 10);
      chk("post_rst_step", 2, cnt_w[2], 12'h001);

      wait_cyc(5);
      chk("sb_empty", 0, q0.size(), 0);
      chk("sb_empty", 1, q1.size(), 0);
      chk("sb_empty", 2, q2.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
